// File: rtl/fetch_decode_fifo_if.sv
// fetch_decode_fifo_if: valid/ready handshake bundle between the fetch unit,
// the fetch/decode elastic buffer and the decoder.
// The slave modport is the buffer itself; the master modport is the
// surrounding pipeline (fetch drives the f_* side, decode drives d_ready).
interface fetch_decode_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  f_valid;
  logic                  f_ready;
  logic [DATA_WIDTH-1:0] f_instruction;
  logic [DATA_WIDTH-1:0] f_pc;
  logic                  d_valid;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_instruction;
  logic [DATA_WIDTH-1:0] d_pc;

  modport master (
    output f_valid, f_instruction, f_pc, d_ready,
    input  f_ready, d_valid, d_instruction, d_pc
  );

  modport slave (
    input  f_valid, f_instruction, f_pc, d_ready,
    output f_ready, d_valid, d_instruction, d_pc
  );
endinterface

// File: rtl/fetch_decode_fifo.sv
// fetch_decode_fifo: DEPTH-entry elastic buffer of (instruction, pc) pairs
// between fetch and decode. Fetch can run ahead while decode is stalled;
// flush discards everything on a branch/jump redirect.
// Optional statistics counters are built only when the macro
// FETCH_DECODE_FIFO_STATS_EN is defined; otherwise the counter outputs are
// tied to zero and the port list is unchanged.
module fetch_decode_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         stall,
  fetch_decode_fifo_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_WIDTH-1:0]         stall_cycles,
  output logic [CNT_WIDTH-1:0]         flush_count
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int OCC_WIDTH = $clog2(DEPTH + 1);
  localparam logic [OCC_WIDTH-1:0] FULL_COUNT = OCC_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [OCC_WIDTH-1:0]  occupancy;
  logic                  has_space;
  logic                  has_entry;
  logic                  head_valid;
  logic                  enq;
  logic                  deq;

  // Readiness depends only on occupancy so fetch never sees a combinational
  // path from its own valid or from decode's ready.
  assign has_space  = (occupancy != FULL_COUNT);
  assign has_entry  = (occupancy != '0);
  assign head_valid = has_entry && !stall;

  // A flushed cycle never stores the fetch entry; a dequeue during flush is
  // still a handshake from decode's point of view and decode drops it.
  assign enq = bus.f_valid && has_space && !flush;
  assign deq = head_valid && bus.d_ready;

  assign bus.f_ready       = has_space;
  assign bus.d_valid       = head_valid;
  assign bus.d_instruction = instr_mem[rd_ptr];
  assign bus.d_pc          = pc_mem[rd_ptr];
  assign count             = occupancy;

  // Storage array: cleared by reset, written at the tail on every accepted
  // enqueue. Flush leaves the contents alone, only the pointers move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem[wr_ptr] <= bus.f_instruction;
      pc_mem[wr_ptr]    <= bus.f_pc;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH
  // is a power of two, and flush snaps everything back to an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      if (enq && !deq) begin
        occupancy <= occupancy + OCC_WIDTH'(1);
      end else if (!enq && deq) begin
        occupancy <= occupancy - OCC_WIDTH'(1);
      end
    end
  end

`ifdef FETCH_DECODE_FIFO_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Saturating statistics: cycles decode was held with work waiting, and
  // cycles a redirect flushed the buffer. Only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && has_entry && (stall_cycles != CNT_MAX)) begin
        stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      end
      if (flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/fetch_decode_fifo.md
# fetch_decode_fifo

Parametrised elastic buffer between the fetch and decode stages of the RISC-V pipeline. Holds up to DEPTH (instruction, pc) pairs with valid/ready handshakes on both sides, plus the flush and stall controls the fetch/decode handoff needs. Sits between the fetch unit and the decoder, so fetch can run ahead while decode is held.

## Interface
Parameters:
- DATA_WIDTH, 32 (riscv_pkg value): instruction and pc width
- DEPTH, 2: entry count; power of two, >= 2
- CNT_WIDTH, 16: width of statistics counters

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all entries (branch/jump redirect)
- stall  in  1  decode hazard hold; blocks dequeue
- f_valid  in  1  fetch presents an entry
- f_ready  out  1  buffer can accept an entry
- f_instruction  in  DATA_WIDTH  fetched instruction
- f_pc  in  DATA_WIDTH  pc of fetched instruction
- d_valid  out  1  head entry presented to decode
- d_ready  in  1  decode accepts head entry
- d_instruction  out  DATA_WIDTH  head instruction
- d_pc  out  DATA_WIDTH  head pc
- count  out  $clog2(DEPTH+1)  current occupancy
- stall_cycles  out  CNT_WIDTH  statistics, see Configuration
- flush_count  out  CNT_WIDTH  statistics, see Configuration

## Operation
- Storage: DEPTH-entry circular register array, wr_ptr/rd_ptr of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0, plus occupancy count.
- Enqueue when f_valid && f_ready && !flush: write {f_instruction, f_pc} at wr_ptr, advance wr_ptr.
- Dequeue when d_valid && d_ready: advance rd_ptr.
- f_ready = (count != DEPTH). Combinational from count only; never depends on f_valid or d_ready.
- d_valid = (count != 0) && !stall.
- d_instruction/d_pc = entry at rd_ptr. Driven even when d_valid=0; when empty they show the stale slot value.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Legal at any count 1..DEPTH-1. At count==DEPTH, f_ready=0, so a full buffer never takes a same-cycle replacement.
- No empty pass-through: an entry written into an empty buffer is not visible until the next cycle.
- stall: dequeue is suppressed even if d_ready=1. Enqueue continues while space remains. Head data stays stable.
- flush (highest priority): next cycle count=0 and wr_ptr=rd_ptr=0. The same-cycle enqueue is dropped even if f_valid&&f_ready. The same-cycle dequeue still counts as accepted by decode, but decode must ignore it. Storage contents are not cleared.
- Reset (async assert, at any time including mid-transfer): count=0, pointers 0, storage cleared to 0, counters 0. Outputs during and after reset: d_valid=0, f_ready=1, d_instruction=0, d_pc=0, count=0, stall_cycles=0, flush_count=0.

## Timing
- Latency: a fetch handshake in cycle N gives d_valid=1 in cycle N+1 at the earliest, with that entry at the head.
- Throughput: 1 entry/cycle sustained when d_ready=1 and stall=0.
- Handshake rules: once f_valid=1, fetch holds f_valid, f_instruction and f_pc until f_ready=1, unless flush occurs. Head data never changes while d_valid=1 and d_ready=0.
- Reset deassertion is synchronised externally. The first enqueue is accepted on the first edge after rst_n rises.

## Configuration
- FETCH_DECODE_FIFO_STATS_EN defined:
  - stall_cycles increments each cycle with stall=1 && count!=0.
  - flush_count increments each cycle with flush=1.
  - Both counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - Both reset to 0 only by rst_n.
- Not defined: stall_cycles and flush_count are tied to 0 and no counter flops are built. The port list is identical in both builds.

## Test plan
- Reset then fill: rst_n low mid-stream with count=2 -> immediately d_valid=0, count=0, f_ready=1. Then with d_ready=0, enqueue pc 0x0, 0x4 -> count=2, f_ready=0, d_pc=0x0.
- Streaming: f_valid=1, d_ready=1 for 8 cycles with pc 0x100 + 4*i -> d_pc sequence 0x100..0x11C, each one cycle after its enqueue, in order, no gaps. Pointers wrap with DEPTH=2 and DEPTH=4.
- Full plus simultaneous events: DEPTH=4 with count=3, then enqueue and dequeue in the same cycle -> count stays 3. At count=4, f_valid held high -> not accepted until the cycle after a dequeue.
- Stall: count=2, stall=1, d_ready=1 for 3 cycles -> d_valid=0, head pc unchanged, count=2. Release stall -> dequeue resumes. With STATS_EN, stall_cycles=3.
- Flush: count=3 with flush=1 and f_valid=1 in the same cycle -> next cycle count=0, d_valid=0, and the new entry is absent. The next enqueue pc 0x200 appears at the head one cycle later. With STATS_EN, flush_count=1.
- Saturation: with STATS_EN and CNT_WIDTH=4, assert flush for 20 cycles -> flush_count=15 and holds. Without the macro, both counters read 0 throughout.
